// File: rtl/intc_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// handshake state encoding and the in-service flag position of ACTIVE_ID.
package intc_pkg;

    localparam int ADDR_PENDING  = 0;
    localparam int ADDR_ENABLE   = 1;
    localparam int ADDR_MODE     = 2;
    localparam int ADDR_VBASE    = 3;
    localparam int ADDR_ACTIVE   = 4;

    localparam int INSERVICE_BIT = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/intc_priority_encoder.sv
// Fixed-priority picker over the eligible vector; the lowest set index wins.
module intc_priority_encoder #(
    parameter int NUM_SOURCES = 8,
    parameter int ID_SIZE     = 5
) (
    input  logic [NUM_SOURCES-1:0] eligible,
    output logic [ID_SIZE-1:0]     winner,
    output logic                   valid
);

    // Scan from the top down so the lowest set index overwrites last.
    always_comb begin
        winner = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_SIZE'(i);
            end
        end
        valid = |eligible;
    end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: edge/level capture into PENDING,
// fixed-priority arbitration and a req/ack/eoi handshake toward the core.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int WORD_SIZE     = 32,
    parameter int ADDR_SIZE     = 5,
    parameter int NUM_SOURCES   = 8,
    parameter int ID_SIZE       = 5,
    parameter int VECTOR_STRIDE = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [ADDR_SIZE-1:0]   addr,
    input  logic [WORD_SIZE-1:0]   wr_data,
    output logic [WORD_SIZE-1:0]   rd_data,
    output logic                   irq_req,
    output logic [WORD_SIZE-1:0]   irq_vector,
    output logic [ID_SIZE-1:0]     irq_id,
    input  logic                   irq_ack,
    input  logic                   eoi
);

    localparam int STRIDE_SHIFT = $clog2(VECTOR_STRIDE);

    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] enable_q, enable_d;
    logic [NUM_SOURCES-1:0] mode_q, mode_d;
    logic [NUM_SOURCES-1:0] src_prev_q;
    logic [WORD_SIZE-1:0]   vbase_q, vbase_d;
    logic [WORD_SIZE-1:0]   rd_data_q;
    logic [WORD_SIZE-1:0]   irq_vector_q;
    logic [ID_SIZE-1:0]     irq_id_q;
    logic                   irq_req_q;
    state_e                 state_q;

    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] id_onehot;
    logic [NUM_SOURCES-1:0] set_vec;
    logic [NUM_SOURCES-1:0] clear_vec;
    logic [ID_SIZE-1:0]     winner;
    logic                   winner_valid;
    logic                   still_valid;
    logic                   ack_take;
    logic [WORD_SIZE-1:0]   winner_vector;
    logic [WORD_SIZE-1:0]   read_word;
    logic                   wr_pending, wr_enable, wr_mode, wr_vbase;

    assign wr_pending = wr_en && (addr == ADDR_SIZE'(ADDR_PENDING));
    assign wr_enable  = wr_en && (addr == ADDR_SIZE'(ADDR_ENABLE));
    assign wr_mode    = wr_en && (addr == ADDR_SIZE'(ADDR_MODE));
    assign wr_vbase   = wr_en && (addr == ADDR_SIZE'(ADDR_VBASE));

    assign eligible      = pending_q & enable_q;
    assign id_onehot     = NUM_SOURCES'(1) << irq_id_q;
    assign still_valid   = |(eligible & id_onehot);
    assign ack_take      = (state_q == REQ) && still_valid && irq_ack;
    assign winner_vector = vbase_q + (WORD_SIZE'(winner) << STRIDE_SHIFT);

    intc_priority_encoder #(
        .NUM_SOURCES(NUM_SOURCES),
        .ID_SIZE    (ID_SIZE)
    ) u_prio (
        .eligible(eligible),
        .winner  (winner),
        .valid   (winner_valid)
    );

    // Sets are ORed in after clears so a new event always beats W1C or ack.
    always_comb begin
        set_vec   = irq_src & ~(mode_q & src_prev_q);
        clear_vec = (wr_pending ? wr_data[NUM_SOURCES-1:0] : '0)
                  | (ack_take ? id_onehot : '0);
        pending_d = (pending_q & ~clear_vec) | set_vec;
        enable_d  = wr_enable ? wr_data[NUM_SOURCES-1:0] : enable_q;
        mode_d    = wr_mode ? wr_data[NUM_SOURCES-1:0] : mode_q;
        vbase_d   = wr_vbase ? wr_data : vbase_q;
    end

    always_comb begin
        read_word = '0;
        case (addr)
            ADDR_SIZE'(ADDR_PENDING): read_word = WORD_SIZE'(pending_q);
            ADDR_SIZE'(ADDR_ENABLE):  read_word = WORD_SIZE'(enable_q);
            ADDR_SIZE'(ADDR_MODE):    read_word = WORD_SIZE'(mode_q);
            ADDR_SIZE'(ADDR_VBASE):   read_word = vbase_q;
            ADDR_SIZE'(ADDR_ACTIVE): begin
                read_word = WORD_SIZE'(irq_id_q);
                read_word[INSERVICE_BIT] = (state_q == SERVICE);
            end
            default:                  read_word = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            vbase_q    <= '0;
            src_prev_q <= '0;
            rd_data_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            vbase_q    <= vbase_d;
            src_prev_q <= irq_src;
            if (rd_en) begin
                rd_data_q <= read_word;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            irq_req_q    <= 1'b0;
            irq_id_q     <= '0;
            irq_vector_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winner_valid) begin
                        irq_id_q     <= winner;
                        irq_vector_q <= winner_vector;
                        irq_req_q    <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    // A withdrawn request is abandoned even if ack arrives with it.
                    if (!still_valid) begin
                        irq_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (irq_ack) begin
                        irq_req_q <= 1'b0;
                        state_q   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    irq_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign rd_data    = rd_data_q;
    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign irq_vector = irq_vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed handshake scenarios plus randomized traffic, every cycle compared
// against a per-source behavioural model of the controller.
module tb_interrupt_controller;

    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic         rd_en = 1'b0;
    logic         wr_en = 1'b0;
    logic [4:0]   addr = '0;
    logic [31:0]  wr_data = '0;
    logic [31:0]  rd_data;
    logic         irq_req;
    logic [31:0]  irq_vector;
    logic [4:0]   irq_id;
    logic         irq_ack = 1'b0;
    logic         eoi = 1'b0;

    interrupt_controller #(
        .WORD_SIZE(32), .ADDR_SIZE(5), .NUM_SOURCES(N), .ID_SIZE(5), .VECTOR_STRIDE(4)
    ) dut (
        .clock(clock), .reset(reset), .irq_src(irq_src), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .irq_req(irq_req),
        .irq_vector(irq_vector), .irq_id(irq_id), .irq_ack(irq_ack), .eoi(eoi)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    endtask

    // Reference model: one bit per source, phase 0=idle 1=requesting 2=in service.
    bit [N-1:0] m_pend, m_en, m_mode, m_prev;
    bit [31:0]  m_vbase, m_vec, m_rd;
    int         m_phase, m_id;
    bit         m_req;

    task automatic model_step();
        int  lowest;
        bit  ack_clr;
        bit  set_i, clr_i;
        if (!reset) begin
            m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0;
            m_vbase = 0; m_vec = 0; m_rd = 0; m_phase = 0; m_id = 0; m_req = 0;
            return;
        end
        if (rd_en) begin
            case (addr)
                5'd0: m_rd = 32'(m_pend);
                5'd1: m_rd = 32'(m_en);
                5'd2: m_rd = 32'(m_mode);
                5'd3: m_rd = m_vbase;
                5'd4: m_rd = 32'(m_id) + ((m_phase == 2) ? 32'h8000_0000 : 32'h0);
                default: m_rd = 0;
            endcase
        end
        lowest = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m_pend[i] && m_en[i]) lowest = i;
        ack_clr = 0;
        if (m_phase == 0) begin
            if (lowest >= 0) begin
                m_id = lowest; m_vec = m_vbase + 32'(lowest) * 4; m_req = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!(m_pend[m_id] && m_en[m_id])) begin
                m_req = 0; m_phase = 0;
            end else if (irq_ack) begin
                m_req = 0; m_phase = 2; ack_clr = 1;
            end
        end else if (eoi) begin
            m_phase = 0;
        end
        for (int i = 0; i < N; i++) begin
            set_i = irq_src[i] && !(m_mode[i] && m_prev[i]);
            clr_i = (wr_en && addr == 5'd0 && wr_data[i]) || (ack_clr && i == m_id);
            m_pend[i] = set_i || (m_pend[i] && !clr_i);
        end
        if (wr_en && addr == 5'd1) m_en = wr_data[N-1:0];
        if (wr_en && addr == 5'd2) m_mode = wr_data[N-1:0];
        if (wr_en && addr == 5'd3) m_vbase = wr_data;
        m_prev = irq_src;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        check_eq("model_req", 32'(irq_req), 32'(m_req));
        check_eq("model_id", 32'(irq_id), 32'(m_id));
        check_eq("model_vec", irq_vector, m_vec);
        check_eq("model_rd", rd_data, m_rd);
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1; addr = a; wr_data = d;
        cyc();
        wr_en = 0;
    endtask

    task automatic reg_read(input logic [4:0] a, input string tag, input logic [31:0] exp);
        rd_en = 1; addr = a;
        cyc();
        rd_en = 0;
        check_eq(tag, rd_data, exp);
    endtask

    task automatic pulse_ack();
        irq_ack = 1; cyc(); irq_ack = 0;
    endtask

    task automatic pulse_eoi();
        eoi = 1; cyc(); eoi = 0;
    endtask

    initial begin
        int  rises;
        bit  last_req;

        // Reset and register readback
        reset = 0; cyc(); cyc();
        reset = 1;
        for (int a = 0; a < 5; a++) reg_read(5'(a), "reset_read", 32'h0);
        check_eq("reset_req", 32'(irq_req), 32'h0);

        // Level request, full handshake
        reg_write(5'd1, 32'h01);
        reg_write(5'd2, 32'h00);
        reg_write(5'd3, 32'h100);
        irq_src = 8'h01; cyc(); irq_src = 8'h00; cyc();
        check_eq("lvl_req", 32'(irq_req), 32'h1);
        check_eq("lvl_vec", irq_vector, 32'h100);
        check_eq("lvl_id", 32'(irq_id), 32'h0);
        pulse_ack();
        check_eq("lvl_req_drop", 32'(irq_req), 32'h0);
        reg_read(5'd0, "lvl_pend_clr", 32'h0);
        reg_read(5'd4, "lvl_active", 32'h8000_0000);
        pulse_eoi(); cyc();
        check_eq("lvl_idle", 32'(irq_req), 32'h0);

        // Priority between two pending sources
        reg_write(5'd1, 32'h0C);
        irq_src = 8'h0C; cyc(); irq_src = 8'h00; cyc();
        check_eq("prio_id2", 32'(irq_id), 32'h2);
        check_eq("prio_vec2", irq_vector, 32'h108);
        pulse_ack(); pulse_eoi(); cyc();
        check_eq("prio_req3", 32'(irq_req), 32'h1);
        check_eq("prio_id3", 32'(irq_id), 32'h3);
        check_eq("prio_vec3", irq_vector, 32'h10C);
        pulse_ack(); pulse_eoi();

        // Edge mode: a held line produces a single request
        reg_write(5'd2, 32'h02);
        reg_write(5'd1, 32'h02);
        rises = 0; last_req = irq_req;
        irq_src = 8'h02;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (irq_req && !last_req) rises++;
            last_req = irq_req;
        end
        check_eq("edge_one_req", 32'(rises), 32'h1);
        check_eq("edge_id", 32'(irq_id), 32'h1);
        pulse_ack();
        reg_read(5'd0, "edge_pend_clr", 32'h0);
        pulse_eoi(); cyc(); cyc();
        check_eq("edge_no_rereq", 32'(irq_req), 32'h0);
        irq_src = 8'h00; cyc(); irq_src = 8'h02; cyc(); irq_src = 8'h00; cyc();
        check_eq("edge_new_req", 32'(irq_req), 32'h1);
        pulse_ack(); pulse_eoi();

        // Rising edge coincident with W1C, then enable withdrawn in REQ
        reg_write(5'd2, 32'h10);
        reg_write(5'd1, 32'h10);
        irq_src = 8'h10; wr_en = 1; addr = 5'd0; wr_data = 32'h10;
        cyc();
        wr_en = 0; irq_src = 8'h00;
        reg_read(5'd0, "w1c_set_wins", 32'h10);
        check_eq("sim_req", 32'(irq_req), 32'h1);
        check_eq("sim_id", 32'(irq_id), 32'h4);
        reg_write(5'd1, 32'h00);
        cyc();
        check_eq("sim_withdraw", 32'(irq_req), 32'h0);
        reg_write(5'd0, 32'hFFFF_FFFF);
        reg_read(5'd0, "w1c_all", 32'h0);

        // Reset while in service
        reg_write(5'd2, 32'h00);
        reg_write(5'd1, 32'h01);
        irq_src = 8'h01; cyc(); irq_src = 8'h00; cyc();
        pulse_ack();
        reg_read(5'd4, "svc_active", 32'h8000_0000);
        reset = 0; cyc(); reset = 1;
        check_eq("rst_req", 32'(irq_req), 32'h0);
        for (int a = 0; a < 5; a++) reg_read(5'(a), "rst_read", 32'h0);
        pulse_eoi(); cyc();
        check_eq("rst_eoi_req", 32'(irq_req), 32'h0);
        reg_read(5'd4, "rst_eoi_active", 32'h0);

        // Randomized traffic against the model
        reg_write(5'd3, 32'hFFFF_FFF0);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
            wr_en   = ($urandom_range(0, 7) == 0);
            addr    = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
            wr_data = $urandom;
            rd_en   = ($urandom_range(0, 2) == 0);
            irq_ack = ($urandom_range(0, 3) == 0);
            eoi     = ($urandom_range(0, 5) == 0);
            reset   = ($urandom_range(0, 299) != 0);
            cyc();
        end
        irq_src = '0; wr_en = 0; rd_en = 0; irq_ack = 0; eoi = 0; reset = 1;
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Parametrised interrupt controller that replaces the flat interrupt register bank. It owns a memory-mapped register set (pending, enable, mode, vector base, active ID) for N external sources. It detects edge- or level-triggered requests and picks the highest-priority source (lowest index wins). It drives a request/acknowledge/end-of-interrupt handshake toward the CPU core and sits between the peripheral IRQ lines and the processor's interrupt entry logic.

Parameters:
WORD_SIZE, 32, data bus width.
ADDR_SIZE, 5, register address width.
NUM_SOURCES, 8, number of interrupt inputs; legal range 1..WORD_SIZE.
ID_SIZE, 5, width of source index; must satisfy 2**ID_SIZE >= NUM_SOURCES.
VECTOR_STRIDE, 4, byte spacing between vectors; must be a power of two.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
irq_src  in  NUM_SOURCES  raw interrupt lines, synchronous to clock.
rd_en  in  1  register read strobe.
wr_en  in  1  register write strobe.
addr  in  ADDR_SIZE  register word address.
wr_data  in  WORD_SIZE  write data.
rd_data  out  WORD_SIZE  registered read data.
irq_req  out  1  interrupt request to core.
irq_vector  out  WORD_SIZE  VECTOR_BASE + irq_id*VECTOR_STRIDE, valid while irq_req is high.
irq_id  out  ID_SIZE  index of the requesting or active source.
irq_ack  in  1  core accepts the request (single-cycle pulse).
eoi  in  1  end of interrupt (single-cycle pulse).

Behaviour:
- Reset: clock is named clock; reset is named reset and is synchronous, active-low. When reset==0 at a rising edge:
  - rd_data, irq_req, irq_id, irq_vector, PENDING, ENABLE, MODE, VECTOR_BASE all become 0.
  - FSM goes to IDLE and the irq_src delay register is cleared.
  - Reset mid-handshake abandons the interrupt silently.
- Register map (word address):
  - 0 PENDING: R, write-1-to-clear.
  - 1 ENABLE: RW.
  - 2 MODE: RW; bit=1 means rising-edge, bit=0 means level.
  - 3 VECTOR_BASE: RW, full width.
  - 4 ACTIVE_ID: R; irq_id zero-extended, bit31 = in-service flag.
  - Other addresses read 0; writes to them are ignored.
  - Bits at and above NUM_SOURCES in regs 0-2 read 0 and ignore writes.
- Reads: rd_data updates one cycle after rd_en and holds its value otherwise. If rd_en and wr_en hit the same address in the same cycle, the read returns the pre-write value.
- Pending set:
  - Level source: set each cycle irq_src[i]==1.
  - Edge source: set when irq_src[i]==1 and the previous sample was 0.
  - Set has priority over a simultaneous W1C clear or ack clear of the same bit.
- Eligible set: PENDING & ENABLE. Winner is the lowest set index.
- FSM:
  - IDLE: if eligible is nonzero, latch winner into irq_id and go to REQ. irq_req rises on the cycle after the eligible bit is seen. irq_ack and eoi are ignored in IDLE.
  - REQ: irq_req=1; irq_id and irq_vector are frozen.
    - On irq_ack: clear PENDING[irq_id] (subject to the set-wins rule), go to SERVICE, drop irq_req.
    - If the latched source's pending or enable bit falls before ack: drop irq_req, return to IDLE.
  - SERVICE: irq_req=0; no new requests are issued; PENDING keeps accumulating.
    - On eoi: go to IDLE. A new arbitration can raise irq_req on the cycle after IDLE is entered.
    - irq_ack in SERVICE is ignored.
  - eoi in REQ is ignored.
- Vector arithmetic: addition is modulo 2**WORD_SIZE (wraps, no flag).
- Level source still high at ack: pending re-sets on the same edge, so it re-requests after eoi.

Decomposition:
- Shared package intc_pkg holds:
  - register address constants (ADDR_PENDING=0, ADDR_ENABLE=1, ADDR_MODE=2, ADDR_VBASE=3, ADDR_ACTIVE=4);
  - FSM state enum {IDLE, REQ, SERVICE};
  - in-service flag bit position (31).
- One sub-module: intc_priority_encoder. Combinational; eligible vector in, winner index plus valid out; lowest index wins.

Test Plan:
- Reset check: apply reset=0 for 2 cycles, then read addresses 0-4 -> all read 0; irq_req=0.
- Level request, full handshake: write ENABLE=0x01, MODE=0, VECTOR_BASE=0x100; pulse irq_src[0] high for 1 cycle -> irq_req=1 next cycle, irq_vector=0x100, irq_id=0. Then irq_ack -> PENDING reads 0, ACTIVE_ID reads 0x80000000. Then eoi -> IDLE, irq_req stays 0.
- Priority: ENABLE=0x0C, sources 2 and 3 both pending -> irq_id=2, irq_vector=base+8. After ack and eoi -> irq_id=3, irq_vector=base+12.
- Edge mode: MODE=0x02, irq_src[1] held high for 10 cycles -> exactly one pending set and one request. A second request appears only after a 0->1 transition.
- Simultaneous events: rising edge on src 4 in the same cycle as a W1C of bit 4 -> PENDING[4] stays 1. Clear ENABLE[4] while in REQ -> irq_req drops and FSM returns to IDLE.
- Reset mid-operation: assert reset in SERVICE -> next cycle FSM is IDLE, all registers are 0, and a later eoi has no effect.
